// File: rtl/v_issue_queue_if.sv
// ---------------------------------------------------------------------------
// v_issue_queue_if
// Scalar-side instruction handshake into the vector issue queue.
//   in_valid : producer offers an instruction
//   in_ready : queue accepts the instruction this cycle
//   in_pkt   : 99-bit packed decoded vector instruction
// Modports: master = scalar pipeline (producer), slave = issue queue.
// ---------------------------------------------------------------------------
interface v_issue_queue_if;
  logic        in_valid;
  logic        in_ready;
  logic [98:0] in_pkt;

  modport master (output in_valid, output in_pkt, input in_ready);
  modport slave  (input in_valid, input in_pkt, output in_ready);
endinterface

// File: rtl/v_issue_queue.sv
// ---------------------------------------------------------------------------
// v_issue_queue
// In-order issue buffer between the scalar pipeline and the vector unit.
// Buffers decoded vector instructions in a DEPTH-entry FIFO and issues them
// as registered single-cycle I_start pulses tagged with a rolling 3-bit id,
// honouring the unit's stall and a bounded in-flight count retired by DONE.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   in_if (slave)   : in_valid / in_ready / in_pkt handshake
//   flush           : drop buffered and in-flight work, pulse I_clear
//   stall           : vector unit cannot accept an issue
//   DONE            : one pulse per completed instruction
//   I_start, I_id   : issue strobe and id (registered)
//   v_pkt           : last issued packet, held until the next issue
//   I_clear         : registered one-cycle pulse following a flush cycle
//   inflight        : issued-but-not-done count
//   empty           : FIFO empty
//   done_err        : sticky, DONE seen with nothing in flight
// ---------------------------------------------------------------------------
module v_issue_queue #(
  parameter int DEPTH        = 4,
  parameter int MAX_INFLIGHT = 2
) (
  input  logic                clk,
  input  logic                reset,
  v_issue_queue_if.slave      in_if,
  input  logic                flush,
  input  logic                stall,
  input  logic                DONE,
  output logic                I_start,
  output logic [2:0]          I_id,
  output logic [98:0]         v_pkt,
  output logic                I_clear,
  output logic [3:0]          inflight,
  output logic                empty,
  output logic                done_err
);

  localparam int          AW     = $clog2(DEPTH);
  localparam logic [3:0]  MAX_IF = 4'(MAX_INFLIGHT);

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0]  wptr, rptr, wptr_next, rptr_next;
  logic [2:0]   id_ctr, id_ctr_next;
  logic [3:0]   inflight_next;
  logic         done_err_next;
  logic         full;
  logic         enq;
  logic         issue;

  logic [98:0]  mem [DEPTH];

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

  assign in_if.in_ready = !full && !reset;

  // Flush wins over everything, so a packet offered with flush is dropped.
  assign enq   = in_if.in_valid && in_if.in_ready && !flush;
  assign issue = !empty && !stall && (inflight < MAX_IF) && !flush;

  // Storage has no reset; validity is tracked purely by the pointers.
  always_ff @(posedge clk) begin
    if (enq) begin
      mem[wptr[AW-1:0]] <= in_if.in_pkt;
    end
  end

  always_comb begin
    wptr_next     = wptr;
    rptr_next     = rptr;
    id_ctr_next   = id_ctr;
    inflight_next = inflight;
    done_err_next = done_err;

    if (flush) begin
      wptr_next     = '0;
      rptr_next     = '0;
      id_ctr_next   = '0;
      inflight_next = '0;
    end else begin
      if (enq) begin
        wptr_next = wptr + 1'b1;
      end
      if (issue) begin
        rptr_next   = rptr + 1'b1;
        id_ctr_next = id_ctr + 3'd1;
      end
      case ({issue, DONE})
        2'b10: inflight_next = inflight + 4'd1;
        2'b01: begin
          if (inflight == 4'd0) begin
            done_err_next = 1'b1;
          end else begin
            inflight_next = inflight - 4'd1;
          end
        end
        2'b11: begin
          // A DONE with nothing in flight cannot retire the new issue.
          if (inflight == 4'd0) begin
            done_err_next = 1'b1;
            inflight_next = inflight + 4'd1;
          end
        end
        default: inflight_next = inflight;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr     <= '0;
      rptr     <= '0;
      id_ctr   <= '0;
      inflight <= '0;
      done_err <= 1'b0;
      I_start  <= 1'b0;
      I_id     <= '0;
      v_pkt    <= '0;
      I_clear  <= 1'b0;
    end else begin
      wptr     <= wptr_next;
      rptr     <= rptr_next;
      id_ctr   <= id_ctr_next;
      inflight <= inflight_next;
      done_err <= done_err_next;
      I_start  <= issue;
      I_clear  <= flush;
      if (issue) begin
        I_id  <= id_ctr;
        v_pkt <= mem[rptr[AW-1:0]];
      end
    end
  end

endmodule

// File: tb/tb_v_issue_queue.sv
// ---------------------------------------------------------------------------
// tb_v_issue_queue
// Directed stimulus with hand-computed expectations for v_issue_queue
// (DEPTH=4, MAX_INFLIGHT=2). Inputs change 1 ns after the rising edge and
// outputs are checked at that same point.
// ---------------------------------------------------------------------------
module tb_v_issue_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        stall;
  logic        DONE;
  logic        I_start;
  logic [2:0]  I_id;
  logic [98:0] v_pkt;
  logic        I_clear;
  logic [3:0]  inflight;
  logic        empty;
  logic        done_err;

  int total = 0;
  int bad   = 0;

  v_issue_queue_if bus ();

  v_issue_queue #(.DEPTH(4), .MAX_INFLIGHT(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_if    (bus),
    .flush    (flush),
    .stall    (stall),
    .DONE     (DONE),
    .I_start  (I_start),
    .I_id     (I_id),
    .v_pkt    (v_pkt),
    .I_clear  (I_clear),
    .inflight (inflight),
    .empty    (empty),
    .done_err (done_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [98:0] got, input logic [98:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  function automatic logic [98:0] mk(input int n);
    logic [98:0] p;
    p = {3'(n), 32'hA5A50000 + 32'(n), 32'h5A5A0000 ^ 32'(n), 32'(n * 7 + 1)};
    return p;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"}, 99'(bus.in_ready), 99'(0));
    check({tag, "_I_start"},  99'(I_start),  99'(0));
    check({tag, "_I_id"},     99'(I_id),     99'(0));
    check({tag, "_v_pkt"},    v_pkt,         99'(0));
    check({tag, "_I_clear"},  99'(I_clear),  99'(0));
    check({tag, "_inflight"}, 99'(inflight), 99'(0));
    check({tag, "_empty"},    99'(empty),    99'(1));
    check({tag, "_done_err"}, 99'(done_err), 99'(0));
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_pkt = '0;
    flush = 1'b0;
    stall = 1'b0;
    DONE = 1'b0;
    tick();
    tick();
    check_reset_vals(tag);
    reset = 1'b0;
    #1;
    check({tag, "_ready_after"}, 99'(bus.in_ready), 99'(1));
  endtask

  initial begin
    // ---------------- reset + single issue latency ----------------
    do_reset("rst0");
    bus.in_valid = 1'b1;
    bus.in_pkt = mk(100);
    tick();                                   // accepted at this edge
    bus.in_valid = 1'b0;
    check("t1_nostart_yet", 99'(I_start), 99'(0));
    check("t1_nonempty", 99'(empty), 99'(0));
    tick();
    check("t1_start", 99'(I_start), 99'(1));
    check("t1_id", 99'(I_id), 99'(0));
    check("t1_pkt", v_pkt, mk(100));
    check("t1_inflight", 99'(inflight), 99'(1));
    tick();
    check("t1_start_pulse", 99'(I_start), 99'(0));
    check("t1_pkt_held", v_pkt, mk(100));
    DONE = 1'b1;
    tick();
    DONE = 1'b0;
    check("t1_retired", 99'(inflight), 99'(0));

    // ---------------- fill under stall, refuse 5th, in-flight limit ----------------
    do_reset("rst1");
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1;
      bus.in_pkt = mk(10 + i);
      tick();
    end
    check("t2_full_ready", 99'(bus.in_ready), 99'(0));
    bus.in_pkt = mk(99);                      // 5th offer must be refused
    tick();
    bus.in_valid = 1'b0;
    check("t2_stall_nostart", 99'(I_start), 99'(0));
    stall = 1'b0;
    tick();
    check("t2_i0_start", 99'(I_start), 99'(1));
    check("t2_i0_id", 99'(I_id), 99'(0));
    check("t2_i0_pkt", v_pkt, mk(10));
    check("t2_i0_ready", 99'(bus.in_ready), 99'(1));
    tick();
    check("t2_i1_start", 99'(I_start), 99'(1));
    check("t2_i1_id", 99'(I_id), 99'(1));
    check("t2_i1_pkt", v_pkt, mk(11));
    check("t2_i1_inflight", 99'(inflight), 99'(2));
    tick();
    check("t2_limit_wait", 99'(I_start), 99'(0));
    check("t2_limit_pkt", v_pkt, mk(11));
    DONE = 1'b1;
    tick();
    DONE = 1'b0;
    check("t2_done1_inflight", 99'(inflight), 99'(1));
    check("t2_done1_nostart", 99'(I_start), 99'(0));
    tick();
    check("t2_i2_start", 99'(I_start), 99'(1));
    check("t2_i2_id", 99'(I_id), 99'(2));
    check("t2_i2_pkt", v_pkt, mk(12));
    DONE = 1'b1;
    tick();
    DONE = 1'b0;
    check("t2_done2_nostart", 99'(I_start), 99'(0));
    tick();
    check("t2_i3_start", 99'(I_start), 99'(1));
    check("t2_i3_id", 99'(I_id), 99'(3));
    check("t2_i3_pkt", v_pkt, mk(13));
    check("t2_drained", 99'(empty), 99'(1));
    tick();
    check("t2_no_fifth", 99'(I_start), 99'(0));
    DONE = 1'b1;
    tick();
    tick();
    DONE = 1'b0;
    check("t2_all_done", 99'(inflight), 99'(0));

    // ---------------- id wrap over 9 issues ----------------
    do_reset("rst2");
    for (int i = 0; i < 9; i++) begin
      bus.in_valid = 1'b1;
      bus.in_pkt = mk(20 + i);
      tick();
      bus.in_valid = 1'b0;
      tick();
      check($sformatf("t3_id%0d", i), 99'(I_id), 99'(i % 8));
      check($sformatf("t3_pkt%0d", i), v_pkt, mk(20 + i));
      DONE = 1'b1;
      tick();
      DONE = 1'b0;
    end
    check("t3_inflight", 99'(inflight), 99'(0));

    // ---------------- DONE coincident with issue, then spurious DONE ----------------
    bus.in_valid = 1'b1;
    bus.in_pkt = mk(40);
    tick();
    bus.in_valid = 1'b1;
    bus.in_pkt = mk(41);
    tick();                                   // D0 issues, D1 accepted
    bus.in_valid = 1'b0;
    check("t4_pre_inflight", 99'(inflight), 99'(1));
    DONE = 1'b1;
    tick();                                   // D1 issues while D0 completes
    DONE = 1'b0;
    check("t4_coinc_start", 99'(I_start), 99'(1));
    check("t4_coinc_id", 99'(I_id), 99'(2));
    check("t4_coinc_inflight", 99'(inflight), 99'(1));
    DONE = 1'b1;
    tick();
    check("t4_zero", 99'(inflight), 99'(0));
    check("t4_no_err_yet", 99'(done_err), 99'(0));
    tick();                                   // DONE with nothing in flight
    DONE = 1'b0;
    check("t4_err", 99'(done_err), 99'(1));
    check("t4_err_inflight", 99'(inflight), 99'(0));
    tick();
    check("t4_err_sticky", 99'(done_err), 99'(1));

    // ---------------- flush with 3 buffered + 2 in flight ----------------
    do_reset("rst3");
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.in_pkt = mk(50 + i);
      tick();
    end
    check("t5_pre_inflight", 99'(inflight), 99'(2));
    check("t5_pre_ready", 99'(bus.in_ready), 99'(1));
    bus.in_pkt = mk(77);
    flush = 1'b1;                             // in_valid still high
    tick();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    check("t5_clear", 99'(I_clear), 99'(1));
    check("t5_empty", 99'(empty), 99'(1));
    check("t5_inflight", 99'(inflight), 99'(0));
    check("t5_nostart", 99'(I_start), 99'(0));
    tick();
    check("t5_clear_pulse", 99'(I_clear), 99'(0));
    check("t5_nothing_enq", 99'(empty), 99'(1));
    check("t5_nostart2", 99'(I_start), 99'(0));
    bus.in_valid = 1'b1;
    bus.in_pkt = mk(60);
    tick();
    bus.in_valid = 1'b0;
    tick();
    check("t5_post_start", 99'(I_start), 99'(1));
    check("t5_post_id", 99'(I_id), 99'(0));
    check("t5_post_pkt", v_pkt, mk(60));
    flush = 1'b1;
    tick();
    check("t5_dflush_a", 99'(I_clear), 99'(1));
    tick();
    flush = 1'b0;
    check("t5_dflush_b", 99'(I_clear), 99'(1));
    tick();
    check("t5_dflush_end", 99'(I_clear), 99'(0));

    // ---------------- reset mid-operation ----------------
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bus.in_valid = 1'b1;
      bus.in_pkt = mk(70 + i);
      tick();
    end
    bus.in_valid = 1'b0;
    check("t6_buffered", 99'(empty), 99'(0));
    reset = 1'b1;
    tick();
    check_reset_vals("t6_rst");
    reset = 1'b0;
    stall = 1'b0;
    tick();
    check("t6_noclear", 99'(I_clear), 99'(0));
    check("t6_empty", 99'(empty), 99'(1));
    check("t6_nostart", 99'(I_start), 99'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety net: the directed sequence is far shorter than this.
  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/v_issue_queue.md
# v_issue_queue

Instruction issue buffer that sits directly upstream of the vector unit wrapper. It accepts decoded vector instructions from the scalar pipeline through a valid/ready handshake and buffers them in a DEPTH-entry FIFO. It issues them in order to the vector unit as single-cycle `I_start` pulses with a rolling 3-bit `I_id`, honouring the unit's `stall` and a bounded in-flight count retired by `DONE`. A flush request drains the buffer and forwards a one-cycle `I_clear` to the vector unit.

## Interface
Parameters:
- `DEPTH`, 4 — FIFO entries; must be a power of 2, ≥2.
- `MAX_INFLIGHT`, 2 — maximum issued-but-not-DONE instructions, 1..8.

Ports:
- `clk`  in  1  — single clock; all state updates on rising edge.
- `reset`  in  1  — synchronous, active-high; clears all state.
- `in_valid`  in  1  — scalar side offers an instruction.
- `in_ready`  out  1  — buffer accepts; equals !full && !reset.
- `in_pkt`  in  99  — packed instruction, MSB→LSB: vs1[5], vs2[5], vd[5], RS1[32], RS2[32], uimm5[5], funct[4], permute[2], mask_en[1], ALUSrc[2], dmr[1], dmw[1], reg_we[1], mem_reg[1], mode_lsu[2].
- `flush`  in  1  — discard all buffered and in-flight instructions.
- `stall`  in  1  — from vector unit; no issue while high.
- `DONE`  in  1  — from vector unit; one-cycle pulse, one per completed instruction.
- `I_start`  out  1  — one-cycle issue strobe, registered.
- `I_id`  out  3  — id of the issued instruction, valid with `I_start`, registered.
- `v_pkt`  out  99  — issued packet, same layout as `in_pkt`; held until the next issue; sliced onto the wrapper's `I_*` ports at the top level.
- `I_clear`  out  1  — one-cycle pulse following a flush, registered.
- `inflight`  out  4  — current issued-not-done count.
- `empty`  out  1  — FIFO empty.
- `done_err`  out  1  — sticky: `DONE` received while `inflight` was 0.

## Operation
- FIFO: DEPTH entries, read/write pointers with one extra wrap bit; full when the pointers differ only in the wrap bit; empty when equal.
- Enqueue occurs when `in_valid && in_ready`: write `in_pkt` at wptr, wptr+1.
- Issue condition, evaluated each cycle on registered state: !empty && !stall && inflight < MAX_INFLIGHT && !flush.
- On issue:
  - at the next edge, `I_start`=1, `v_pkt`=head entry, `I_id`=id_ctr;
  - id_ctr increments mod 8 (7→0 wraps);
  - rptr+1, inflight+1.
- `I_start` is 0 on every non-issue cycle. Back-to-back issues on consecutive cycles are allowed.
- `DONE`: inflight−1. Issue and `DONE` in the same cycle leave inflight unchanged.
- If `DONE` arrives with inflight==0: inflight stays 0 and `done_err` sets; it clears only on reset.
- Simultaneous enqueue and issue with a full FIFO: enqueue is refused because `in_ready` is low that cycle. No read-before-write bypass.
- `flush` has priority over enqueue, issue and `DONE` in the same cycle. At the next edge:
  - pointers reset, so empty=1;
  - inflight=0, id_ctr=0;
  - `I_clear`=1 for exactly one cycle and `I_start`=0.
- Consecutive flush cycles produce `I_clear` high for each cycle.

## Timing
- Reset values: `I_start`=0, `I_id`=0, `v_pkt`=0, `I_clear`=0, `inflight`=0, `empty`=1, `done_err`=0, `in_ready`=0 while reset is high, then 1.
- Reset asserted mid-operation discards buffered entries without an `I_clear` pulse. The vector unit is reset by the same signal.
- Latency: an entry accepted at edge k, with an empty FIFO and the issue condition true, shows `I_start`=1 during cycle k+1→k+2.
- `stall` high at the decision cycle delays issue by exactly the stall duration. The head entry and `v_pkt` are unchanged meanwhile.
- Throughput: 1 instruction/cycle when unstalled and under MAX_INFLIGHT.
- `DONE` at edge k frees a slot. An issue blocked only by MAX_INFLIGHT fires at edge k+1.

## Test plan
- Reset, then enqueue pkt A with `stall`=0 → `I_start` pulse 1 cycle after acceptance, `I_id`=0, `v_pkt`=A, `inflight`=1.
- Enqueue 4 pkts, DEPTH=4, with `stall`=1 → `in_ready`=0 after the 4th and a 5th `in_valid` is refused. Release stall → issues ids 0,1 back-to-back, then waits. Two `DONE` pulses → ids 2,3 issue.
- Issue 9 instructions with a `DONE` after each → `I_id` sequence 0..7,0.
- `DONE` in the same cycle as an issue with `inflight`=1 → `inflight` stays 1. Then `DONE` with `inflight`=0 → `done_err`=1, `inflight`=0.
- 3 entries buffered plus 2 in flight; `flush` together with `in_valid` → next cycle `I_clear`=1, `empty`=1, `inflight`=0, nothing enqueued, no `I_start`. The next issue carries `I_id`=0.
- Reset asserted while 2 entries are buffered and `stall`=1 → all outputs return to reset values and no `I_clear` pulse is produced.
